// File: rtl/ppu_vram_arb.sv
// PPU VRAM bus arbiter: renderer fetches (bg > spr) pre-empt a single queued CPU 0x2007 access.
// Optional `PPU_VRAM_ARB_RDBUF_EN selects 0x2007 read-buffer emulation.
module ppu_vram_arb (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        render_en_in,
  input  logic        bg_req_in,
  input  logic [13:0] bg_a_in,
  input  logic        spr_req_in,
  input  logic [13:0] spr_a_in,
  input  logic        ri_req_in,
  input  logic        ri_wr_in,
  input  logic [13:0] ri_a_in,
  input  logic [7:0]  ri_d_in,
  input  logic [7:0]  vram_d_in,
  output logic [13:0] vram_a_out,
  output logic [7:0]  vram_d_out,
  output logic        vram_wr_out,
  output logic        bg_gnt_out,
  output logic        spr_gnt_out,
  output logic        ri_busy_out,
  output logic        ri_done_out,
  output logic [7:0]  ri_rd_data_out,
  output logic        ri_ovf_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        wr_q;
  logic [13:0] a_q;
  logic [7:0]  d_q;
  logic [7:0]  rd_q;
  logic        ovf_q;

  logic bg_gnt, spr_gnt, render_gnt;
  logic busy, accept, cpu_acc, rd_cap;

  assign bg_gnt     = render_en_in & bg_req_in;
  assign spr_gnt    = render_en_in & spr_req_in & ~bg_req_in;
  assign render_gnt = bg_gnt | spr_gnt;

  // DONE is not busy, so a request arriving there is accepted back-to-back
  assign busy    = (state_q == ST_PEND) | (state_q == ST_ACC);
  assign accept  = ri_req_in & ~busy;
  assign cpu_acc = (state_q == ST_ACC) & ~render_gnt;
  assign rd_cap  = cpu_acc & ~wr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_PEND;
      ST_PEND: if (!render_gnt) state_d = ST_ACC;
      ST_ACC:  if (!render_gnt) state_d = ST_DONE;
      ST_DONE: state_d = accept ? ST_PEND : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      a_q     <= '0;
      d_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q <= ri_wr_in;
        a_q  <= ri_a_in;
        d_q  <= ri_d_in;
      end
      if (ri_req_in && busy) ovf_q <= 1'b1;
    end
  end

`ifdef PPU_VRAM_ARB_RDBUF_EN
  logic [7:0] rdbuf_q;

  // Palette space bypasses the delay buffer, but the buffer still reloads
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rdbuf_q <= '0;
      rd_q    <= '0;
    end else if (rd_cap) begin
      rdbuf_q <= vram_d_in;
      rd_q    <= (a_q < 14'h3F00) ? rdbuf_q : vram_d_in;
    end
  end
`else
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rd_q <= '0;
    else if (rd_cap) rd_q <= vram_d_in;
  end
`endif

  assign vram_a_out     = bg_gnt ? bg_a_in : (spr_gnt ? spr_a_in : a_q);
  assign vram_d_out     = d_q;
  assign vram_wr_out    = cpu_acc & wr_q;
  assign bg_gnt_out     = bg_gnt;
  assign spr_gnt_out    = spr_gnt;
  assign ri_busy_out    = busy;
  assign ri_done_out    = (state_q == ST_DONE);
  assign ri_rd_data_out = rd_q;
  assign ri_ovf_out     = ovf_q;

endmodule

// File: doc/ppu_vram_arb.md
PPU_VRAM_ARB -- requirements
Module: ppu_vram_arb

Interface
REQ-001 Ports SHALL be:
- clk_in  in  1  50MHz system clock
- rst_n_in  in  1  reset, asynchronous, active-low
- render_en_in  in  1  rendering enabled (bg or spr)
- bg_req_in  in  1  background fetch request, level, this cycle
- bg_a_in  in  14  background fetch address
- spr_req_in  in  1  sprite fetch request, level, this cycle
- spr_a_in  in  14  sprite fetch address
- ri_req_in  in  1  CPU 0x2007 access request, 1-cycle pulse
- ri_wr_in  in  1  1=write, 0=read; qualified by ri_req_in
- ri_a_in  in  14  CPU VRAM address; qualified by ri_req_in
- ri_d_in  in  8  CPU write data; qualified by ri_req_in
- vram_d_in  in  8  VRAM read data, valid same cycle as vram_a_out
- vram_a_out  out  14  VRAM address bus
- vram_d_out  out  8  VRAM write data
- vram_wr_out  out  1  VRAM write strobe, 1 cycle per write
- bg_gnt_out  out  1  bg owns bus this cycle
- spr_gnt_out  out  1  spr owns bus this cycle
- ri_busy_out  out  1  CPU access pending or in progress
- ri_done_out  out  1  1-cycle pulse, CPU access complete
- ri_rd_data_out  out  8  CPU read result
- ri_ovf_out  out  1  sticky: ri_req_in dropped while busy
REQ-002 Clock SHALL be clk_in; reset SHALL be rst_n_in, asynchronous assert, active-low, synchronous deassert handled externally.

Function
REQ-003 Render requests SHALL be valid only when render_en_in=1; otherwise ignored, grants low.
REQ-004 Grant SHALL be combinational, priority bg > spr > CPU; vram_a_out = granted requester's address same cycle.
REQ-005 No requester granted: vram_a_out SHALL equal the latched CPU address (ri_a_in captured at last accepted request), 14'h0000 after reset.
REQ-006 CPU request accepted when ri_req_in=1 and ri_busy_out=0: latch ri_wr_in/ri_a_in/ri_d_in, ri_busy_out=1 next cycle.
REQ-007 ri_req_in=1 while ri_busy_out=1 SHALL be dropped and ri_ovf_out set to 1 until reset.
REQ-008 CPU FSM states: IDLE, PEND, ACC, DONE.
REQ-009 IDLE -> PEND on accepted request; PEND -> ACC on the first cycle with no render grant (PEND lasts ≥1 cycle).
REQ-010 ACC: if no render grant this cycle, drive CPU address; write: vram_wr_out=1, vram_d_out=latched data; read: capture vram_d_in at clock edge; -> DONE.
REQ-011 ACC with render grant present SHALL not strobe or capture and SHALL remain in ACC (retry).
REQ-012 DONE: ri_done_out=1 for exactly one cycle, ri_busy_out=0 in same cycle, -> IDLE; a new ri_req_in in DONE SHALL be accepted.
REQ-013 Best-case latency request pulse to ri_done_out SHALL be 3 cycles (PEND, ACC, DONE).
REQ-014 vram_wr_out SHALL never assert in a cycle where bg_gnt_out or spr_gnt_out is 1.
REQ-015 vram_d_out SHALL hold latched CPU write data at all times (0x00 after reset).
REQ-016 ri_rd_data_out SHALL update only on DONE following a read; writes leave it unchanged.

Reset
REQ-017 On rst_n_in=0: FSM=IDLE, pending access discarded, vram_wr_out=0, ri_busy_out=0, ri_done_out=0, ri_ovf_out=0, ri_rd_data_out=8'h00, latched address/data=0, read buffer=8'h00.
REQ-018 Reset asserted in ACC SHALL suppress the write strobe in that cycle.

Configuration
REQ-019 Macro PPU_VRAM_ARB_RDBUF_EN SHALL select 0x2007 read-buffer emulation.
REQ-020 Defined: read of address < 14'h3F00 SHALL return previous buffer contents on ri_rd_data_out and load buffer with fetched byte; address ≥ 14'h3F00 SHALL return fetched byte directly and also load buffer.
REQ-021 Undefined: ri_rd_data_out SHALL always be the fetched byte; no buffer register exists.

Verification
REQ-022 render_en_in=0, write ri_a=14'h2000 d=8'h5A -> vram_wr_out=1 once with vram_a_out=14'h2000, vram_d_out=8'h5A; ri_done_out 3 cycles after request.
REQ-023 bg_req_in held 1 (render_en_in=1) for 10 cycles, CPU write pending -> no vram_wr_out during those 10 cycles; write completes cycle after bg_req_in drops; ri_done_out follows next cycle.
REQ-024 bg_req_in and spr_req_in both 1 -> bg_gnt_out=1, spr_gnt_out=0, vram_a_out=bg_a_in; bg drops -> spr_gnt_out=1, vram_a_out=spr_a_in.
REQ-025 RDBUF_EN defined, VRAM[0x2100]=8'h11, VRAM[0x2101]=8'h22: read 0x2100 -> 8'h00, read 0x2101 -> 8'h11; read 0x3F00 (value 8'h0F) -> 8'h0F; undefined -> 8'h11, 8'h22.
REQ-026 Second ri_req_in one cycle after first -> second dropped, ri_ovf_out=1 stays set; only one ri_done_out; rst_n_in low during ACC of a write -> no vram_wr_out, all outputs at reset values.
